fetch_stall_ctrl: RTL and testbench

Front-end pipeline control for the 5-stage RV32I core. It owns the fetch PC register and the IF/ID pipeline register, and turns the hazard unit's `stall` request and the execute-stage branch resolution into concrete actions. Those actions are: hold PC and IF/ID, load a NOP, redirect the PC, and inject a bubble into ID/EX. It also keeps stall/flush performance counters and a stall watchdog that flags a stall held longer than the worst-case pipeline drain.

---
 rtl/core_pkg.sv | 14 +
 rtl/if_id_reg.sv | 43 ++++
 rtl/fetch_stall_ctrl.sv | 112 +++++++++++
 tb/tb_fetch_stall_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core front end.
// Holds the canonical NOP encoding, XLEN and the stall FSM state type.
package core_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        RUN,
        STALL
    } stall_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instruction, PC, PC+4 and valid.
// clr loads a NOP bubble and wins over en; en low holds the contents.
module if_id_reg
    import core_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            en_i,
    input  logic            clr_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] pc_plus4_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            valid_o
);

    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_plus4_q;
    logic            valid_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            instr_q    <= NOP_INSTR;
            pc_q       <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else if (en_i) begin
            instr_q    <= instr_i;
            pc_q       <= pc_i;
            pc_plus4_q <= pc_plus4_i;
            valid_q    <= 1'b1;
        end
    end

    assign instr_o    = instr_q;
    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stall_ctrl.sv
// Front-end control: fetch PC, IF/ID register, stall/flush handling,
// performance counters and a watchdog on over-long stall runs.
module fetch_stall_ctrl
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          CNT_W     = 32,
    parameter int          STALL_MAX = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch_taken_E,
    input  logic [31:0]      branch_target_E,
    input  logic [31:0]      instr_F,
    output logic [31:0]      pc_F,
    output logic [31:0]      instr_D,
    output logic [31:0]      pc_D,
    output logic [31:0]      pc_plus4_D,
    output logic             valid_D,
    output logic             flush_E,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             stall_err
);

    localparam int RUN_W = $clog2(STALL_MAX + 2);
    localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(STALL_MAX + 1);

    logic             stall_eff;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      pc_plus4;
    stall_state_e     state_q;
    logic [RUN_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic             err_q;

    // A bubble in D never has real source operands, so it cannot stall.
    assign stall_eff = stall & valid_D;
    assign flush_E   = branch_taken_E | stall_eff;
    assign pc_plus4  = pc_q + 32'd4;

    always_comb begin
        pc_d = pc_plus4;
        if (branch_taken_E) begin
            pc_d = branch_target_E;
        end else if (stall_eff) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    always_comb begin
        run_d = RUN_W'(1);
        if (state_q == STALL) begin
            run_d = (run_q == RUN_LIM) ? RUN_LIM : run_q + RUN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            run_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            if (stall_eff && !branch_taken_E) begin
                state_q     <= STALL;
                run_q       <= run_d;
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
                if (run_d == RUN_LIM) begin
                    err_q <= 1'b1;
                end
            end else begin
                state_q <= RUN;
                run_q   <= '0;
            end
            if (branch_taken_E) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    if_id_reg u_if_id (
        .clk        (clk),
        .rst        (rst),
        .en_i       (!stall_eff),
        .clr_i      (branch_taken_E),
        .instr_i    (instr_F),
        .pc_i       (pc_q),
        .pc_plus4_i (pc_plus4),
        .instr_o    (instr_D),
        .pc_o       (pc_D),
        .pc_plus4_o (pc_plus4_D),
        .valid_o    (valid_D)
    );

    assign pc_F      = pc_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign stall_err = err_q;

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Directed bench for fetch_stall_ctrl with RESET_PC=0x100, STALL_MAX=3.
// The instruction memory returns pc+0x1000_0000 so each word is traceable.
module tb_fetch_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken_E;
    logic [31:0] branch_target_E;
    logic [31:0] instr_F;
    logic [31:0] pc_F;
    logic [31:0] instr_D;
    logic [31:0] pc_D;
    logic [31:0] pc_plus4_D;
    logic        valid_D;
    logic        flush_E;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    logic        stall_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign instr_F = pc_F + 32'h1000_0000;

    fetch_stall_ctrl #(
        .RESET_PC  (32'h0000_0100),
        .CNT_W     (32),
        .STALL_MAX (3)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .branch_taken_E  (branch_taken_E),
        .branch_target_E (branch_target_E),
        .instr_F         (instr_F),
        .pc_F            (pc_F),
        .instr_D         (instr_D),
        .pc_D            (pc_D),
        .pc_plus4_D      (pc_plus4_D),
        .valid_D         (valid_D),
        .flush_E         (flush_E),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt),
        .stall_err       (stall_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pc_F"}, pc_F, 32'h100);
        chk({tag, "_instr_D"}, instr_D, 32'h13);
        chk({tag, "_pc_D"}, pc_D, 32'h0);
        chk({tag, "_pc4_D"}, pc_plus4_D, 32'h0);
        chk({tag, "_valid_D"}, {31'b0, valid_D}, 32'h0);
        chk({tag, "_stall_cnt"}, stall_cnt, 32'h0);
        chk({tag, "_flush_cnt"}, flush_cnt, 32'h0);
        chk({tag, "_stall_err"}, {31'b0, stall_err}, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        branch_taken_E = 1'b0;
        branch_target_E = 32'h0;
        step();
        chk_reset("rst0");
        chk("rst0_flush_E", {31'b0, flush_E}, 32'h0);

        // stall while D is empty is masked
        rst = 1'b0;
        stall = 1'b1;
        #1;
        chk("mask_flush_E", {31'b0, flush_E}, 32'h0);
        step();
        chk("adv1_pc_F", pc_F, 32'h104);
        chk("adv1_instr_D", instr_D, 32'h1000_0100);
        chk("adv1_pc_D", pc_D, 32'h100);
        chk("adv1_pc4_D", pc_plus4_D, 32'h104);
        chk("adv1_valid_D", {31'b0, valid_D}, 32'h1);
        chk("adv1_stall_cnt", stall_cnt, 32'h0);

        stall = 1'b0;
        step();
        chk("adv2_pc_F", pc_F, 32'h108);
        step();
        chk("adv3_pc_F", pc_F, 32'h10C);
        chk("adv3_instr_D", instr_D, 32'h1000_0108);

        // two-cycle stall
        stall = 1'b1;
        #1;
        chk("st1_flush_E", {31'b0, flush_E}, 32'h1);
        step();
        chk("st1_pc_F", pc_F, 32'h10C);
        chk("st1_instr_D", instr_D, 32'h1000_0108);
        chk("st1_flush_E2", {31'b0, flush_E}, 32'h1);
        step();
        chk("st2_pc_F", pc_F, 32'h10C);
        chk("st2_pc_D", pc_D, 32'h108);
        chk("st2_stall_cnt", stall_cnt, 32'h2);
        chk("st2_stall_err", {31'b0, stall_err}, 32'h0);

        // branch coincident with stall: branch wins
        branch_taken_E = 1'b1;
        branch_target_E = 32'h200;
        #1;
        chk("br_flush_E", {31'b0, flush_E}, 32'h1);
        step();
        chk("br_pc_F", pc_F, 32'h200);
        chk("br_instr_D", instr_D, 32'h13);
        chk("br_valid_D", {31'b0, valid_D}, 32'h0);
        chk("br_flush_cnt", flush_cnt, 32'h1);
        chk("br_stall_cnt", stall_cnt, 32'h2);

        branch_taken_E = 1'b0;
        #1;
        chk("br_mask_flush_E", {31'b0, flush_E}, 32'h0);
        step();
        chk("br_tgt_pc_F", pc_F, 32'h204);
        chk("br_tgt_instr_D", instr_D, 32'h1000_0200);
        chk("br_tgt_pc_D", pc_D, 32'h200);
        chk("br_tgt_stall_cnt", stall_cnt, 32'h2);

        // four-cycle stall run trips the watchdog on the 4th edge
        step();
        step();
        step();
        chk("wd3_stall_cnt", stall_cnt, 32'h5);
        chk("wd3_stall_err", {31'b0, stall_err}, 32'h0);
        chk("wd3_pc_F", pc_F, 32'h204);
        step();
        chk("wd4_stall_cnt", stall_cnt, 32'h6);
        chk("wd4_stall_err", {31'b0, stall_err}, 32'h1);
        stall = 1'b0;
        step();
        chk("wd_rel_pc_F", pc_F, 32'h208);
        chk("wd_rel_stall_err", {31'b0, stall_err}, 32'h1);
        chk("wd_rel_stall_cnt", stall_cnt, 32'h6);

        rst = 1'b1;
        step();
        chk_reset("rst1");
        rst = 1'b0;

        // PC wrap at the top of the address space
        branch_taken_E = 1'b1;
        branch_target_E = 32'hFFFF_FFFC;
        step();
        chk("wrap_br_pc_F", pc_F, 32'hFFFF_FFFC);
        chk("wrap_br_flush_cnt", flush_cnt, 32'h1);
        branch_taken_E = 1'b0;
        step();
        chk("wrap_pc_F", pc_F, 32'h0);
        chk("wrap_pc_D", pc_D, 32'hFFFF_FFFC);
        chk("wrap_pc4_D", pc_plus4_D, 32'h0);
        chk("wrap_instr_D", instr_D, 32'h0FFF_FFFC);

        // reset mid-stall with a branch pending
        stall = 1'b1;
        step();
        chk("ms_stall_cnt", stall_cnt, 32'h1);
        chk("ms_pc_F", pc_F, 32'h0);
        rst = 1'b1;
        branch_taken_E = 1'b1;
        branch_target_E = 32'h300;
        step();
        chk_reset("rst2");
        rst = 1'b0;
        branch_taken_E = 1'b0;
        #1;
        chk("rst2_flush_E", {31'b0, flush_E}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
